// File: rtl/i2c_wr_master.sv
// Write-only I2C master: sends a START, three bytes {dev+W, reg, val} MSB first with ACK slots, then a STOP.
// Optional build macro I2C_ACK_CHECK_EN: sample ACK slots, flag NACK on ack_err and cut to STOP.
module i2c_wr_master #(
    parameter int QTR_DIV = 30
) (
    input  logic        clk_12M,
    input  logic        rstn,
    input  logic        start,
    input  logic [23:0] i2c_data,
    output logic        busy,
    output logic        tr_end,
    output logic        ack_err,
    output logic        i2c_sclk,
    inout  wire         i2c_sdat
);
    localparam int CW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;

    typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, DONE} state_t;

    state_t      state;
    logic [CW-1:0] qcnt;
    logic        tick;
    logic [1:0]  qtr;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] sr;
    logic        sda_oe;
`ifdef I2C_ACK_CHECK_EN
    logic        nack;
`endif

    // Open drain: only ever pull low or let go.
    assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;
    assign tick     = busy && (qcnt == CW'(QTR_DIV - 1));

    always_ff @(posedge clk_12M) begin
        if (!rstn || !busy || tick) qcnt <= '0;
        else                        qcnt <= qcnt + 1'b1;
    end

    // Each tick closes quarter qtr and sets the lines for the following quarter.
    always_ff @(posedge clk_12M) begin
        if (!rstn) begin
            state    <= IDLE;
            i2c_sclk <= 1'b1;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            tr_end   <= 1'b0;
            qtr      <= 2'd0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
            sr       <= 24'd0;
`ifdef I2C_ACK_CHECK_EN
            nack     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    i2c_sclk <= 1'b1;
                    sda_oe   <= 1'b0;
                    qtr      <= 2'd0;
                    if (start && !tr_end) begin
                        sr    <= i2c_data;
                        busy  <= 1'b1;
                        state <= START;
`ifdef I2C_ACK_CHECK_EN
                        nack  <= 1'b0;
`endif
                    end
                end
                START: if (tick) begin
                    qtr <= qtr + 2'd1;
                    case (qtr)
                        2'd0: sda_oe   <= 1'b1;
                        2'd2: i2c_sclk <= 1'b0;
                        2'd3: begin
                            state    <= BIT;
                            bit_cnt  <= 3'd7;
                            byte_cnt <= 2'd0;
                            sda_oe   <= ~sr[23];
                        end
                        default: ;
                    endcase
                end
                BIT: if (tick) begin
                    qtr <= qtr + 2'd1;
                    case (qtr)
                        2'd1: i2c_sclk <= 1'b1;
                        2'd3: begin
                            i2c_sclk <= 1'b0;
                            sr       <= {sr[22:0], 1'b0};
                            if (bit_cnt == 3'd0) begin
                                state  <= ACK;
                                sda_oe <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                                sda_oe  <= ~sr[22];
                            end
                        end
                        default: ;
                    endcase
                end
                ACK: if (tick) begin
                    qtr <= qtr + 2'd1;
                    case (qtr)
                        2'd1: i2c_sclk <= 1'b1;
`ifdef I2C_ACK_CHECK_EN
                        2'd2: if (i2c_sdat) nack <= 1'b1;
`endif
                        2'd3: begin
                            i2c_sclk <= 1'b0;
`ifdef I2C_ACK_CHECK_EN
                            if (nack || byte_cnt == 2'd2) begin
`else
                            if (byte_cnt == 2'd2) begin
`endif
                                state  <= STOP;
                                sda_oe <= 1'b1;
                            end else begin
                                state    <= BIT;
                                byte_cnt <= byte_cnt + 2'd1;
                                bit_cnt  <= 3'd7;
                                sda_oe   <= ~sr[23];
                            end
                        end
                        default: ;
                    endcase
                end
                STOP: if (tick) begin
                    qtr <= qtr + 2'd1;
                    case (qtr)
                        2'd0: i2c_sclk <= 1'b1;
                        2'd1: sda_oe   <= 1'b0;
                        2'd3: begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            tr_end <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                DONE: begin
                    // Hold the completion flag until the sequencer drops start.
                    if (!start) begin
                        tr_end <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef I2C_ACK_CHECK_EN
    assign ack_err = nack;
`else
    assign ack_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_wr_master.sv
// Bench for i2c_wr_master: slave/bus monitor plus a transfer-level reference model, random and directed transfers.
module tb_i2c_wr_master;
    localparam int QTR  = 30;
    localparam int SLOT = 4 * QTR;
`ifdef I2C_ACK_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk_12M = 1'b0;
    logic        rstn    = 1'b0;
    logic        start   = 1'b0;
    logic [23:0] i2c_data = 24'd0;
    logic        busy, tr_end, ack_err, i2c_sclk;
    wire         i2c_sdat;
    logic        slave_low = 1'b0;

    pullup (i2c_sdat);
    assign i2c_sdat = slave_low ? 1'b0 : 1'bz;

    i2c_wr_master #(.QTR_DIV(QTR)) dut (
        .clk_12M (clk_12M),
        .rstn    (rstn),
        .start   (start),
        .i2c_data(i2c_data),
        .busy    (busy),
        .tr_end  (tr_end),
        .ack_err (ack_err),
        .i2c_sclk(i2c_sclk),
        .i2c_sdat(i2c_sdat)
    );

    always #42 clk_12M = ~clk_12M;

    longint cyc = 0;
    always @(posedge clk_12M) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Bus monitor and slave: decodes bytes on SCL rise, counts START/STOP, acks per nack_mask.
    logic       p_scl = 1'b1, p_sda = 1'b1;
    int         bcnt = 0, n_start = 0, n_stop = 0, n_rise = 0, bad_sda = 0;
    logic [8:0] bsh = '0;
    logic [7:0] bus_q[$];
    logic [2:0] nack_mask = '0;
    longint     t_r0 = 0, t_r1 = 0;

    always @(negedge clk_12M) begin
        if (!rstn) begin
            p_scl     = 1'b1;
            p_sda     = 1'b1;
            bcnt      = 0;
            slave_low <= 1'b0;
        end else begin
            if (i2c_sdat !== 1'b0 && i2c_sdat !== 1'b1) bad_sda++;
            if (p_scl && i2c_sclk && i2c_sdat != p_sda) begin
                if (!i2c_sdat) begin
                    n_start++;
                    bcnt   = 0;
                    n_rise = 0;
                end else n_stop++;
            end else if (!p_scl && i2c_sclk) begin
                if (n_rise == 0) t_r0 = cyc;
                else if (n_rise == 1) t_r1 = cyc;
                n_rise++;
                bsh = {bsh[7:0], i2c_sdat};
                bcnt++;
                if (bcnt == 9) begin
                    bus_q.push_back(bsh[8:1]);
                    bcnt = 0;
                end
            end
            if (!i2c_sclk)
                slave_low <= (bcnt == 8) && (bus_q.size() < 3) && !nack_mask[bus_q.size()];
            p_scl = i2c_sclk;
            p_sda = i2c_sdat;
        end
    end

    task automatic xfer(input logic [23:0] d, input logic [2:0] nm, input int hold, input bit early_drop);
        int     ns, exp_cyc, viol;
        bit     ok;
        logic   exp_err;
        longint t0;
        // Reference: bytes sent stop after the first NACK only when checking is built in.
        ns = 3;
        exp_err = 1'b0;
        if (CHK_EN)
            for (int i = 2; i >= 0; i--) if (nm[i]) ns = i + 1;
        for (int i = 0; i < ns; i++) if (CHK_EN && nm[i]) exp_err = 1'b1;
        exp_cyc = (2 + 9 * ns) * SLOT;

        nack_mask = nm;
        bus_q.delete();
        n_start = 0;
        n_stop  = 0;
        @(negedge clk_12M);
        i2c_data = d;
        start    = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_12M);
            if (busy) begin ok = 1'b1; break; end
        end
        chk("accept", 32'(ok), 1);
        t0 = cyc;
        i2c_data = 24'($urandom);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk_12M);
            if (early_drop && i == 200) start = 1'b0;
            if (tr_end) begin ok = 1'b1; break; end
        end
        chk("done_seen", 32'(ok), 1);
        chk("latency", 32'(cyc - t0), 32'(exp_cyc));
        chk("busy_at_end", 32'(busy), 0);
        chk("ack_err", 32'(ack_err), 32'(exp_err));
        chk("nbytes", 32'(bus_q.size()), 32'(ns));
        for (int i = 0; i < ns && i < bus_q.size(); i++)
            chk("byte", 32'(bus_q[i]), 32'(d[23 - 8 * i -: 8]));
        chk("stop_cnt", 32'(n_stop), 1);
        chk("scl_period", 32'(t_r1 - t_r0), 32'(SLOT));
        if (start) begin
            viol = 0;
            repeat (hold) begin
                @(negedge clk_12M);
                if (!tr_end || busy) viol++;
            end
            chk("hold_tr_end", 32'(viol), 0);
            start = 1'b0;
        end
        @(negedge clk_12M);
        chk("tr_end_clr", 32'(tr_end), 0);
        chk("start_cnt", 32'(n_start), 1);
    endtask

    initial begin
        bit ok;
        repeat (4) @(negedge clk_12M);
        chk("rst_scl", 32'(i2c_sclk), 1);
        chk("rst_sda", 32'(i2c_sdat), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tr_end", 32'(tr_end), 0);
        chk("rst_ack_err", 32'(ack_err), 0);
        rstn = 1'b1;
        repeat (3) @(negedge clk_12M);

        xfer(24'h200080, 3'b000, 500, 1'b0);
        xfer(24'h2013A0, 3'b001, 20, 1'b0);

        // Abort with reset while SCL is high on bit 4 of the second byte.
        nack_mask = 3'b000;
        bus_q.delete();
        n_start = 0;
        n_stop  = 0;
        @(negedge clk_12M);
        i2c_data = 24'h5AC3E1;
        start    = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk_12M);
            if (bus_q.size() == 1 && bcnt == 4) begin ok = 1'b1; break; end
        end
        chk("reach_b2b4", 32'(ok), 1);
        rstn  = 1'b0;
        start = 1'b0;
        @(negedge clk_12M);
        chk("abort_scl", 32'(i2c_sclk), 1);
        chk("abort_sda", 32'(i2c_sdat), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_tr_end", 32'(tr_end), 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk_12M);
        chk("abort_no_stop", 32'(n_stop), 0);
        xfer(24'h20163F, 3'b000, 5, 1'b0);

        for (int k = 0; k < 6; k++) begin
            logic [2:0] nm;
            bit         ed;
            nm = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            ed = 1'($urandom_range(0, 1));
            xfer(24'($urandom), nm, ed ? 0 : $urandom_range(1, 30), ed);
        end

        chk("sda_legal", 32'(bad_sda), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
